// File: rtl/riscv_lsu_pkg.sv
// Shared load/store size codes, LSU state encodings and byte-lane helpers.
// Size codes follow the RISC-V funct3 encoding of loads and stores.
package riscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  function automatic logic [3:0] be_of(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_B, LDST_BU: be_of = 4'b0001 << off;
      LDST_H, LDST_HU: be_of = 4'b0011 << {off[1], 1'b0};
      LDST_W:          be_of = 4'b1111;
      default:         be_of = 4'b0000;
    endcase
  endfunction

  // Replicate narrow store data onto every lane so byte enables alone select it.
  function automatic logic [31:0] wd_of(input logic [2:0] size, input logic [31:0] wd);
    case (size)
      LDST_B:  wd_of = {4{wd[7:0]}};
      LDST_H:  wd_of = {2{wd[15:0]}};
      default: wd_of = wd;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_H, LDST_HU: misaligned = off[0];
      LDST_W:          misaligned = |off;
      default:         misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Core-request and data-memory signals of the load-store unit.
// master = core/memory side driving requests and read data, slave = the LSU.
interface riscv_lsu_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_req_o;
  logic        core_err_o;
  logic        core_misalign_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_req_o, core_err_o, core_misalign_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );

  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_req_o, core_err_o, core_misalign_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/riscv_lsu_fmt.sv
// Combinational load formatter: selects the byte/half at the latched offset
// and sign- or zero-extends it; unknown size codes return zero.
module riscv_lsu_fmt
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] mem_rd_i,
  output logic [31:0] rd_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shifted  = mem_rd_i >> {off_i, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = off_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

  always_comb begin
    rd_o = 32'h0;
    case (size_i)
      LDST_B:  rd_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: rd_o = {24'h0, byte_sel};
      LDST_H:  rd_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: rd_o = {16'h0, half_sel};
      LDST_W:  rd_o = mem_rd_i;
      default: rd_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: registers a word-aligned memory request, stalls the core
// until mem_ready_i or timeout, then formats load data. Optional: RISCV_LSU_MISALIGN_EN.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter logic [31:0] RESET_RD    = 32'h0
) (
  input  logic       clk_i,
  input  logic       arstn_i,
  riscv_lsu_if.slave bus
);

  localparam int unsigned          CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam bit                   TMO_EN   = (TIMEOUT_CYC != 0);

  lsu_state_e       state_q, state_d;
  logic             we_q;
  logic [2:0]       size_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_req_q, mem_we_q;
  logic [3:0]       mem_be_q;
  logic [31:0]      mem_addr_q, mem_wd_q;
  logic [31:0]      rd_q;
  logic             err_q;
  logic [31:0]      fmt_rd;
  logic             accept, mis_now, tmo_hit;

  assign accept  = (state_q == IDLE) && bus.core_req_i;
  assign tmo_hit = TMO_EN && (cnt_q == CNT_LAST);

`ifdef RISCV_LSU_MISALIGN_EN
  logic mis_q;

  assign mis_now = misaligned(bus.core_size_i, bus.core_addr_i[1:0]);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      mis_q <= 1'b0;
    end else if (accept) begin
      mis_q <= mis_now;
    end
  end

  assign bus.core_misalign_o = mis_q;
`else
  assign mis_now             = 1'b0;
  assign bus.core_misalign_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ready wins over timeout when both land in the same WAIT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.core_req_i) state_d = mis_now ? DONE : WAIT;
      WAIT: if (bus.mem_ready_i || tmo_hit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.core_stall_req_o = 1'b0;
    case (state_q)
      IDLE:    bus.core_stall_req_o = bus.core_req_i;
      WAIT:    bus.core_stall_req_o = 1'b1;
      default: bus.core_stall_req_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      we_q       <= 1'b0;
      size_q     <= LDST_W;
      off_q      <= 2'b00;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= 4'b0000;
      mem_addr_q <= 32'h0;
      mem_wd_q   <= 32'h0;
      rd_q       <= RESET_RD;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.core_req_i) begin
            we_q   <= bus.core_we_i;
            size_q <= bus.core_size_i;
            off_q  <= bus.core_addr_i[1:0];
            err_q  <= 1'b0;
            if (!mis_now) begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= bus.core_we_i;
              mem_be_q   <= be_of(bus.core_size_i, bus.core_addr_i[1:0]);
              mem_addr_q <= {bus.core_addr_i[31:2], 2'b00};
              mem_wd_q   <= wd_of(bus.core_size_i, bus.core_wd_i);
              cnt_q      <= '0;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus.mem_ready_i) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b0;
            if (!we_q) rd_q <= fmt_rd;
          end else if (tmo_hit) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  riscv_lsu_fmt u_fmt (
    .size_i   (size_q),
    .off_i    (off_q),
    .mem_rd_i (bus.mem_rd_i),
    .rd_o     (fmt_rd)
  );

  assign bus.mem_req_o  = mem_req_q;
  assign bus.mem_we_o   = mem_we_q;
  assign bus.mem_be_o   = mem_be_q;
  assign bus.mem_addr_o = mem_addr_q;
  assign bus.mem_wd_o   = mem_wd_q;
  assign bus.core_rd_o  = rd_q;
  assign bus.core_err_o = err_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: loads, stores, formatting, timeout, async reset
// and (when RISCV_LSU_MISALIGN_EN is defined) misaligned-access abort.
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;

  localparam logic [31:0] RST_RD = 32'hCAFE0001;

  logic clk;
  logic arstn;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [31:0] exp_rd;

  riscv_lsu_if bus ();

  riscv_lsu #(.TIMEOUT_CYC(16), .RESET_RD(RST_RD)) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents a request in IDLE, checks the combinational stall, then moves
  // to the first WAIT cycle with the request withdrawn.
  task automatic issue(input logic we, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd);
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = we;
    bus.core_size_i = sz;
    bus.core_addr_i = a;
    bus.core_wd_i   = wd;
    #1;
    chk("stall_req_cycle", {31'b0, bus.core_stall_req_o}, 32'd1);
    tick;
    bus.core_req_i = 1'b0;
  endtask

  task automatic complete(input logic [31:0] rdata);
    bus.mem_rd_i    = rdata;
    bus.mem_ready_i = 1'b1;
    tick;
    bus.mem_ready_i = 1'b0;
  endtask

  initial begin
    int n;
    int guard;
    arstn           = 1'b0;
    bus.core_req_i  = 1'b0;
    bus.core_we_i   = 1'b0;
    bus.core_size_i = LDST_W;
    bus.core_addr_i = 32'h0;
    bus.core_wd_i   = 32'h0;
    bus.mem_rd_i    = 32'h0;
    bus.mem_ready_i = 1'b0;
    #12;
    chk("rst_mem_req", {31'b0, bus.mem_req_o}, 32'd0);
    chk("rst_mem_we", {31'b0, bus.mem_we_o}, 32'd0);
    chk("rst_mem_be", {28'b0, bus.mem_be_o}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst_mem_wd", bus.mem_wd_o, 32'h0);
    chk("rst_core_rd", bus.core_rd_o, RST_RD);
    chk("rst_err", {31'b0, bus.core_err_o}, 32'd0);
    chk("rst_misalign", {31'b0, bus.core_misalign_o}, 32'd0);
    chk("rst_stall", {31'b0, bus.core_stall_req_o}, 32'd0);
    @(posedge clk);
    #1;
    arstn = 1'b1;
    tick;

    // LW @0x104, ready in first WAIT cycle
    issue(1'b0, LDST_W, 32'h104, 32'h0);
    chk("lw_mem_req", {31'b0, bus.mem_req_o}, 32'd1);
    chk("lw_mem_addr", bus.mem_addr_o, 32'h104);
    chk("lw_mem_be", {28'b0, bus.mem_be_o}, 32'hF);
    chk("lw_mem_we", {31'b0, bus.mem_we_o}, 32'd0);
    chk("lw_stall_wait", {31'b0, bus.core_stall_req_o}, 32'd1);
    complete(32'hDEADBEEF);
    chk("lw_rd", bus.core_rd_o, 32'hDEADBEEF);
    chk("lw_stall_done", {31'b0, bus.core_stall_req_o}, 32'd0);
    chk("lw_req_drop", {31'b0, bus.mem_req_o}, 32'd0);
    chk("lw_err", {31'b0, bus.core_err_o}, 32'd0);
    tick;

    // LB / LBU @0x103
    issue(1'b0, LDST_B, 32'h103, 32'h0);
    chk("lb_mem_be", {28'b0, bus.mem_be_o}, 32'h8);
    chk("lb_mem_addr", bus.mem_addr_o, 32'h100);
    complete(32'h80112233);
    chk("lb_rd", bus.core_rd_o, 32'hFFFFFF80);
    tick;
    issue(1'b0, LDST_BU, 32'h103, 32'h0);
    complete(32'h80112233);
    chk("lbu_rd", bus.core_rd_o, 32'h00000080);
    tick;

    // LH upper half, sign extended; LHU lower half with ready delayed 2 cycles
    issue(1'b0, LDST_H, 32'h102, 32'h0);
    chk("lh_mem_be", {28'b0, bus.mem_be_o}, 32'hC);
    complete(32'h80112233);
    chk("lh_rd", bus.core_rd_o, 32'hFFFF8011);
    tick;
    issue(1'b0, LDST_HU, 32'h100, 32'h0);
    chk("lhu_mem_be", {28'b0, bus.mem_be_o}, 32'h3);
    tick;
    tick;
    chk("lhu_hold_req", {31'b0, bus.mem_req_o}, 32'd1);
    chk("lhu_hold_be", {28'b0, bus.mem_be_o}, 32'h3);
    chk("lhu_hold_stall", {31'b0, bus.core_stall_req_o}, 32'd1);
    complete(32'h80118233);
    chk("lhu_rd", bus.core_rd_o, 32'h00008233);
    exp_rd = 32'h00008233;
    tick;

    // SH @0x202: stores must not touch core_rd_o
    issue(1'b1, LDST_H, 32'h202, 32'h0000ABCD);
    chk("sh_mem_we", {31'b0, bus.mem_we_o}, 32'd1);
    chk("sh_mem_be", {28'b0, bus.mem_be_o}, 32'hC);
    chk("sh_mem_wd", bus.mem_wd_o, 32'hABCDABCD);
    chk("sh_mem_addr", bus.mem_addr_o, 32'h200);
    complete(32'h12345678);
    chk("sh_rd_kept", bus.core_rd_o, exp_rd);
    tick;

    // SB @0x001
    issue(1'b1, LDST_B, 32'h001, 32'h123456EF);
    chk("sb_mem_be", {28'b0, bus.mem_be_o}, 32'h2);
    chk("sb_mem_wd", bus.mem_wd_o, 32'hEFEFEFEF);
    complete(32'h0);
    tick;

    // Unknown size code: no byte enables, load returns zero
    issue(1'b0, 3'b011, 32'h0, 32'h0);
    chk("unk_mem_be", {28'b0, bus.mem_be_o}, 32'h0);
    complete(32'hFFFFFFFF);
    chk("unk_rd", bus.core_rd_o, 32'h0);
    exp_rd = 32'h0;
    tick;

    // Ready strobe in IDLE is ignored
    bus.mem_rd_i    = 32'h55555555;
    bus.mem_ready_i = 1'b1;
    tick;
    tick;
    bus.mem_ready_i = 1'b0;
    chk("idle_rdy_req", {31'b0, bus.mem_req_o}, 32'd0);
    chk("idle_rdy_rd", bus.core_rd_o, exp_rd);

    // Timeout: ready withheld
    issue(1'b0, LDST_W, 32'h300, 32'h0);
    n     = (bus.mem_req_o === 1'b1) ? 1 : 0;
    guard = 0;
    while (bus.mem_req_o === 1'b1 && guard < 40) begin
      tick;
      guard++;
      if (bus.mem_req_o === 1'b1) n++;
    end
    chk("tmo_wait_cycles", n, 32'd16);
    chk("tmo_err", {31'b0, bus.core_err_o}, 32'd1);
    chk("tmo_stall_done", {31'b0, bus.core_stall_req_o}, 32'd0);
    chk("tmo_rd_kept", bus.core_rd_o, exp_rd);
    tick;
    issue(1'b0, LDST_W, 32'h304, 32'h0);
    complete(32'h0BADF00D);
    chk("post_tmo_rd", bus.core_rd_o, 32'h0BADF00D);
    chk("post_tmo_err", {31'b0, bus.core_err_o}, 32'd0);
    tick;

    // Async reset during WAIT
    issue(1'b0, LDST_W, 32'h400, 32'h0);
    chk("arst_pre_req", {31'b0, bus.mem_req_o}, 32'd1);
    #2;
    arstn = 1'b0;
    #1;
    chk("arst_req", {31'b0, bus.mem_req_o}, 32'd0);
    chk("arst_rd", bus.core_rd_o, RST_RD);
    chk("arst_stall", {31'b0, bus.core_stall_req_o}, 32'd0);
    @(posedge clk);
    #1;
    arstn = 1'b1;
    tick;
    issue(1'b0, LDST_W, 32'h408, 32'h0);
    chk("arst_new_addr", bus.mem_addr_o, 32'h408);
    complete(32'h13579BDF);
    chk("arst_new_rd", bus.core_rd_o, 32'h13579BDF);
    chk("arst_new_err", {31'b0, bus.core_err_o}, 32'd0);
    exp_rd = 32'h13579BDF;
    tick;

`ifdef RISCV_LSU_MISALIGN_EN
    issue(1'b0, LDST_W, 32'h101, 32'h0);
    chk("mis_req", {31'b0, bus.mem_req_o}, 32'd0);
    chk("mis_flag", {31'b0, bus.core_misalign_o}, 32'd1);
    chk("mis_stall_done", {31'b0, bus.core_stall_req_o}, 32'd0);
    chk("mis_rd_kept", bus.core_rd_o, exp_rd);
    tick;
    chk("mis_idle_req", {31'b0, bus.mem_req_o}, 32'd0);
    issue(1'b0, LDST_W, 32'h104, 32'h0);
    chk("mis_clear", {31'b0, bus.core_misalign_o}, 32'd0);
    complete(32'h2468ACE0);
    chk("mis_next_rd", bus.core_rd_o, 32'h2468ACE0);
    tick;
`else
    issue(1'b0, LDST_W, 32'h101, 32'h0);
    chk("nomis_addr", bus.mem_addr_o, 32'h100);
    chk("nomis_be", {28'b0, bus.mem_be_o}, 32'hF);
    complete(32'h2468ACE0);
    chk("nomis_flag", {31'b0, bus.core_misalign_o}, 32'd0);
    chk("nomis_rd", bus.core_rd_o, 32'h2468ACE0);
    tick;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load-store unit. It is the responder side of the core's memory-request interface: it accepts the decoder-driven request (req, we, size) plus the ALU address and the rs2 data. It drives a word-organised data memory with byte enables, formats load data, and holds the core stalled until each access completes. It sits between the execute stage and the data memory.

Parameters:
TIMEOUT_CYC, 16, max cycles spent in WAIT before aborting; 0 disables the timeout.
RESET_RD, 32'h0, value of core_rd_o after reset.

Ports:
clk_i  in  1  clock, all state updates on rising edge
arstn_i  in  1  asynchronous active-low reset
core_req_i  in  1  access request from decoder (mem_req)
core_we_i  in  1  1 = store, 0 = load
core_size_i  in  3  LDST_B/H/W/BU/HU code
core_addr_i  in  32  byte address from ALU
core_wd_i  in  32  store data (rs2)
core_rd_o  out  32  formatted load data, valid in DONE
core_stall_req_o  out  1  hold PC/pipeline while high
core_err_o  out  1  timeout abort, valid in DONE
core_misalign_o  out  1  misaligned access flag, valid in DONE
mem_req_o  out  1  memory request, registered
mem_we_o  out  1  memory write enable, registered
mem_be_o  out  4  byte enables, registered
mem_addr_o  out  32  word address {addr[31:2],2'b00}, registered
mem_wd_o  out  32  replicated store data, registered
mem_rd_i  in  32  memory read word
mem_ready_i  in  1  memory completion strobe

Behaviour:
- Reset (async, arstn_i=0): state=IDLE. mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wd_o=0. core_rd_o=RESET_RD, core_err_o=0, core_misalign_o=0, timeout counter=0. A reset mid-access drops mem_req_o immediately and the access is lost.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - core_stall_req_o = core_req_i (combinational).
  - On core_req_i: latch we, size, addr[1:0]. Register mem_* outputs. mem_req_o<=1, counter<=0, go to WAIT.
- WAIT:
  - stall=1. mem_* outputs are held stable.
  - Counter increments each cycle.
  - On mem_ready_i: mem_req_o<=0. For a load, core_rd_o<=fmt(mem_rd_i). core_err_o<=0. Go to DONE.
  - If TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1 without ready: mem_req_o<=0, core_err_o<=1, go to DONE.
  - mem_ready_i takes priority over the timeout when both occur in the same cycle.
- DONE:
  - stall=0 for exactly one cycle, go to IDLE.
  - core_req_i is ignored in DONE. The next instruction's request is seen in IDLE.
- Minimum latency: request in cycle 0, mem_req_o=1 in cycle 1, mem_ready_i in cycle 1, DONE in cycle 2. Stall is high in cycles 0-1.
- core_rd_o changes only on load completion; stores leave it unchanged.
- mem_ready_i in IDLE or DONE is ignored.
- Byte enables:
  - B/BU: 4'b0001<<addr[1:0]
  - H/HU: 4'b0011<<{addr[1],1'b0}
  - W: 4'b1111
  - Loads also drive these enables.
- Store data:
  - B: {4{wd[7:0]}}
  - H: {2{wd[15:0]}}
  - W: wd
- Load format, using the latched offset:
  - B: byte at offset, sign-extended
  - BU: byte at offset, zero-extended
  - H: half at addr[1], sign-extended
  - HU: half at addr[1], zero-extended
  - W: full word
  - An unknown size code gives mem_be_o=0 and core_rd_o=0.

Optional Feature:
RISCV_LSU_MISALIGN_EN.
- Defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, issues no memory request.
  - IDLE goes straight to DONE.
  - core_misalign_o=1 in DONE; core_rd_o is unchanged.
  - core_misalign_o is cleared on the next accepted access.
- Undefined: core_misalign_o is tied 0. Offending low address bits are ignored, so H uses addr[1] and W uses word alignment.

Decomposition:
- Shared header defines.v holds:
  - LDST_B/H/W/BU/HU codes
  - the LSU state encodings IDLE=2'd0, WAIT=2'd1, DONE=2'd2
- One combinational sub-module, riscv_lsu_fmt: inputs (size, offset, mem_rd), output formatted 32-bit load data. It is instantiated once.

Test Plan:
- LW @0x104, mem_rd_i=0xDEADBEEF, ready in the first WAIT cycle -> mem_addr_o=0x104, be=4'b1111. core_rd_o=0xDEADBEEF in DONE. Stall high exactly 2 cycles.
- LB @0x103, mem_rd_i=0x80112233 -> be=4'b1000, core_rd_o=0xFFFFFF80. LBU at the same address -> core_rd_o=0x00000080.
- SH @0x202, wd=0x0000ABCD -> mem_we_o=1, be=4'b1100, mem_wd_o=0xABCDABCD, mem_addr_o=0x200. core_rd_o unchanged.
- Ready withheld with TIMEOUT_CYC=16 -> mem_req_o falls after 16 WAIT cycles, core_err_o=1 in DONE, stall low for one cycle.
- arstn_i pulsed low during WAIT -> mem_req_o=0 asynchronously, state IDLE. A new request afterwards completes normally.
- With RISCV_LSU_MISALIGN_EN: LW @0x101 -> mem_req_o never asserted, core_misalign_o=1 in DONE, stall high 1 cycle.
